// File: rtl/fetch_pkg.sv
// Types and constants shared by the fetch path: responder state encoding,
// instruction word width, wait counter width and the decode bubble encoding.
package fetch_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [WORD_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction storage: synchronous write, combinational read,
// no reset so preloaded contents survive a core reset.
module imem_array
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A read racing a write on the same edge sees the old word.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: valid/ready request channel,
// LATENCY-cycle access, held response under decode stall, redirect flush.
module imem_responder
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [WORD_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_instr,
  output logic [WORD_W-1:0] resp_pc,
  input  logic              flush,
  input  logic              load_en,
  input  logic [WORD_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  if (LATENCY == 0 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY must lie in 1..15");
  end

  localparam bit               SINGLE   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  fetch_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] rpc_q, rpc_d;
  logic              valid_q, valid_d;

  logic              accept_c;
  logic [ADDR_W-1:0] raddr_c;
  logic [WORD_W-1:0] rdata_c;
  logic              unused_load_hi;

  assign unused_load_hi = ^load_addr[WORD_W-1:ADDR_W];

  // Flush forces ready so a redirected PC is taken in the flush cycle.
  assign req_ready = !rst && (flush || state_q == IDLE || (state_q == RESP && resp_ready));
  assign accept_c  = req_valid && req_ready;
  assign raddr_c   = (SINGLE && accept_c) ? req_addr[ADDR_W-1:0] : pc_q[ADDR_W-1:0];

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (load_en),
    .waddr_i (load_addr[ADDR_W-1:0]),
    .wdata_i (load_data),
    .raddr_i (raddr_c),
    .rdata_o (rdata_c)
  );

  // Next-state: accept (incl. redirect) > flush > normal progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rpc_d   = rpc_q;
    valid_d = valid_q;

    if (accept_c) begin
      pc_d = req_addr;
      if (SINGLE) begin
        instr_d = rdata_c;
        rpc_d   = req_addr;
        valid_d = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d   = CNT_LOAD;
        valid_d = 1'b0;
        state_d = WAIT;
      end
    end else if (flush) begin
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            instr_d = rdata_c;
            rpc_d   = pc_q;
            valid_d = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      rpc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rpc_q   <= rpc_d;
      valid_q <= valid_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_instr = instr_q;
  assign resp_pc    = rpc_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 2, 3) share stimulus;
// directed scenarios plus a random run against a transaction-level model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        resp_ready;
  logic        flush;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  logic [2:0]  rdy;
  logic [2:0]  rv;
  logic [15:0] ri [3];
  logic [15:0] rp [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    imem_responder #(.ADDR_W(8), .LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (rdy[g]),
      .resp_valid (rv[g]),
      .resp_ready (resp_ready),
      .resp_instr (ri[g]),
      .resp_pc    (rp[g]),
      .flush      (flush),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data)
    );
  end

  // Reference model: per instance, an outstanding transaction with a
  // countdown to visibility; the word is captured on the edge it becomes visible.
  logic [15:0] mem_m  [256];
  logic        busy_m [3] = '{default: 1'b0};
  int unsigned rem_m  [3] = '{default: 0};
  logic [15:0] pc_m   [3];
  logic [15:0] ins_m  [3];
  logic [15:0] opc_m  [3];

  function automatic logic exp_valid(int k);
    return busy_m[k] && rem_m[k] == 0;
  endfunction

  function automatic logic exp_ready(int k);
    return !rst && (flush || !busy_m[k] || (exp_valid(k) && resp_ready));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        busy_m[k] <= 1'b0;
        ins_m[k]  <= 16'h0000;
        opc_m[k]  <= 16'h0000;
      end else if (req_valid && exp_ready(k)) begin
        busy_m[k] <= 1'b1;
        rem_m[k]  <= k;
        pc_m[k]   <= req_addr;
        if (k == 0) begin
          ins_m[k] <= mem_m[req_addr[7:0]];
          opc_m[k] <= req_addr;
        end
      end else if (flush || (exp_valid(k) && resp_ready)) begin
        busy_m[k] <= 1'b0;
      end else if (busy_m[k] && rem_m[k] > 0) begin
        rem_m[k] <= rem_m[k] - 1;
        if (rem_m[k] == 1) begin
          ins_m[k] <= mem_m[pc_m[k][7:0]];
          opc_m[k] <= pc_m[k];
        end
      end
    end
    if (load_en) mem_m[load_addr[7:0]] <= load_data;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req_valid = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_addr = 16'h0010; flush = 1'b1; resp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks += 4;
      if (rdy[k] !== 1'b0) begin n_errors++; $display("FAIL reset_ready k=%0d got=%b exp=0", k, rdy[k]); end
      if (rv[k] !== 1'b0)  begin n_errors++; $display("FAIL reset_valid k=%0d got=%b exp=0", k, rv[k]); end
      if (ri[k] !== 16'h0) begin n_errors++; $display("FAIL reset_instr k=%0d got=%h exp=0000", k, ri[k]); end
      if (rp[k] !== 16'h0) begin n_errors++; $display("FAIL reset_pc k=%0d got=%h exp=0000", k, rp[k]); end
    end
    rst = 1'b0;
    quiet();
    next_cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rdy[k] !== 1'b1) begin n_errors++; $display("FAIL idle_ready k=%0d got=%b exp=1", k, rdy[k]); end
    end
    next_cycle();
  endtask

  task automatic test_preload();
    for (int i = 0; i < 256; i++) begin
      load_en   = 1'b1;
      load_addr = {8'($urandom), 8'(i)};
      load_data = (i == 16'h10) ? 16'hA5A5 : (i == 16'h30) ? 16'hBEEF : 16'($urandom);
      next_cycle();
    end
    load_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_basic();
    for (int j = 0; j <= 4; j++) begin
      req_valid = (j == 0); req_addr = 16'h0010; resp_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (j == 0 && rdy[k] !== 1'b1) begin n_errors++; $display("FAIL basic_ready k=%0d got=%b exp=1", k, rdy[k]); end
        if (rv[k] !== (j == k + 1)) begin n_errors++; $display("FAIL basic_valid k=%0d j=%0d got=%b exp=%b", k, j, rv[k], j == k + 1); end
        if (j == k + 1) begin
          n_checks += 2;
          if (ri[k] !== 16'hA5A5) begin n_errors++; $display("FAIL basic_instr k=%0d got=%h exp=a5a5", k, ri[k]); end
          if (rp[k] !== 16'h0010) begin n_errors++; $display("FAIL basic_pc k=%0d got=%h exp=0010", k, rp[k]); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stream();
    for (int j = 0; j <= 4; j++) begin
      req_valid = (j < 4); req_addr = 16'(j); resp_ready = 1'b1;
      @(negedge clk);
      if (j < 4) begin
        n_checks++;
        if (rdy[0] !== 1'b1) begin n_errors++; $display("FAIL stream_ready j=%0d got=%b exp=1", j, rdy[0]); end
      end
      if (j >= 1) begin
        n_checks += 3;
        if (rv[0] !== 1'b1) begin n_errors++; $display("FAIL stream_valid j=%0d got=%b exp=1", j, rv[0]); end
        if (rp[0] !== 16'(j - 1)) begin n_errors++; $display("FAIL stream_pc j=%0d got=%h exp=%h", j, rp[0], 16'(j - 1)); end
        if (ri[0] !== mem_m[8'(j - 1)]) begin n_errors++; $display("FAIL stream_instr j=%0d got=%h exp=%h", j, ri[0], mem_m[8'(j - 1)]); end
      end
      next_cycle();
    end
    quiet();
    repeat (6) next_cycle();
  endtask

  task automatic test_stall();
    logic [15:0] old;
    old = mem_m[8'h55];
    for (int j = 0; j <= 9; j++) begin
      req_valid  = (j == 0) || (j >= 3 && j <= 7);
      req_addr   = (j == 0) ? 16'h0055 : 16'h0099;
      resp_ready = (j >= 8);
      load_en    = (j == 4); load_addr = 16'h0055; load_data = ~old;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (j >= 3 && j <= 7) begin
          n_checks += 4;
          if (rv[k] !== 1'b1)     begin n_errors++; $display("FAIL stall_valid k=%0d j=%0d got=%b exp=1", k, j, rv[k]); end
          if (rdy[k] !== 1'b0)    begin n_errors++; $display("FAIL stall_ready k=%0d j=%0d got=%b exp=0", k, j, rdy[k]); end
          if (ri[k] !== old)      begin n_errors++; $display("FAIL stall_instr k=%0d j=%0d got=%h exp=%h", k, j, ri[k], old); end
          if (rp[k] !== 16'h0055) begin n_errors++; $display("FAIL stall_pc k=%0d j=%0d got=%h exp=0055", k, j, rp[k]); end
        end else if (j == 8) begin
          n_checks += 2;
          if (rv[k] !== 1'b1)  begin n_errors++; $display("FAIL release_valid k=%0d got=%b exp=1", k, rv[k]); end
          if (rdy[k] !== 1'b1) begin n_errors++; $display("FAIL release_ready k=%0d got=%b exp=1", k, rdy[k]); end
        end else if (j == 9) begin
          n_checks++;
          if (rv[k] !== 1'b0)  begin n_errors++; $display("FAIL after_release_valid k=%0d got=%b exp=0", k, rv[k]); end
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_flush();
    for (int j = 0; j <= 5; j++) begin
      req_valid = (j <= 1); req_addr = (j == 0) ? 16'h0020 : 16'h0040;
      flush = (j == 1); resp_ready = 1'b1;
      @(negedge clk);
      if (j == 1) begin
        n_checks += 2;
        if (rv[0] !== 1'b1 || rp[0] !== 16'h0020) begin
          n_errors++; $display("FAIL flush_l1_old got=%b/%h exp=1/0020", rv[0], rp[0]);
        end
        for (int k = 0; k < 3; k++) begin
          if (rdy[k] !== 1'b1) begin n_errors++; $display("FAIL flush_ready k=%0d got=%b exp=1", k, rdy[k]); end
        end
      end
      if (j >= 2) begin
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (rv[k] !== (j == k + 2)) begin n_errors++; $display("FAIL flush_valid k=%0d j=%0d got=%b exp=%b", k, j, rv[k], j == k + 2); end
          if (j == k + 2) begin
            n_checks += 2;
            if (rp[k] !== 16'h0040) begin n_errors++; $display("FAIL flush_pc k=%0d got=%h exp=0040", k, rp[k]); end
            if (ri[k] !== mem_m[8'h40]) begin n_errors++; $display("FAIL flush_instr k=%0d got=%h exp=%h", k, ri[k], mem_m[8'h40]); end
          end
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_rbw();
    logic [15:0] old;
    logic        ev;
    logic [15:0] ei;
    old = mem_m[8'h30];
    for (int j = 0; j <= 9; j++) begin
      req_valid = (j == 0) || (j == 5); req_addr = 16'h0030; resp_ready = 1'b1;
      load_en = (j == 1); load_addr = 16'h0030; load_data = 16'h1234;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        ev = (j == k + 1) || (j == k + 6);
        ei = (j >= 6 || k == 2) ? 16'h1234 : old;
        n_checks++;
        if (rv[k] !== ev) begin n_errors++; $display("FAIL rbw_valid k=%0d j=%0d got=%b exp=%b", k, j, rv[k], ev); end
        if (ev) begin
          n_checks++;
          if (ri[k] !== ei) begin n_errors++; $display("FAIL rbw_instr k=%0d j=%0d got=%h exp=%h", k, j, ri[k], ei); end
        end
      end
      next_cycle();
    end
    quiet();
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j <= 4; j++) begin
      req_valid = (j == 0); req_addr = 16'h0077; rst = (j == 1); resp_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (j == 1) begin
          n_checks++;
          if (rdy[k] !== 1'b0) begin n_errors++; $display("FAIL rstmid_ready k=%0d got=%b exp=0", k, rdy[k]); end
        end
        if (j >= 2) begin
          n_checks++;
          if (rv[k] !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid k=%0d j=%0d got=%b exp=0", k, j, rv[k]); end
        end
        if (j == 2) begin
          n_checks++;
          if (ri[k] !== 16'h0 || rp[k] !== 16'h0) begin
            n_errors++; $display("FAIL rstmid_regs k=%0d got=%h/%h exp=0000/0000", k, ri[k], rp[k]);
          end
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    quiet();
  endtask

  task automatic test_alias();
    for (int j = 0; j <= 3; j++) begin
      req_valid = (j == 0); req_addr = 16'h0110; resp_ready = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (rv[k] !== (j == k + 1)) begin n_errors++; $display("FAIL alias_valid k=%0d j=%0d got=%b exp=%b", k, j, rv[k], j == k + 1); end
        if (j == k + 1) begin
          n_checks += 2;
          if (ri[k] !== 16'hA5A5) begin n_errors++; $display("FAIL alias_instr k=%0d got=%h exp=a5a5", k, ri[k]); end
          if (rp[k] !== 16'h0110) begin n_errors++; $display("FAIL alias_pc k=%0d got=%h exp=0110", k, rp[k]); end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_addr   = 16'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      load_en    = ($urandom_range(0, 3) == 0);
      load_addr  = 16'($urandom);
      load_data  = 16'($urandom);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_checks += 2;
        if (rv[k] !== exp_valid(k)) begin n_errors++; $display("FAIL rand_valid k=%0d n=%0d got=%b exp=%b", k, n, rv[k], exp_valid(k)); end
        if (rdy[k] !== exp_ready(k)) begin n_errors++; $display("FAIL rand_ready k=%0d n=%0d got=%b exp=%b", k, n, rdy[k], exp_ready(k)); end
        if (exp_valid(k)) begin
          n_checks += 2;
          if (ri[k] !== ins_m[k]) begin n_errors++; $display("FAIL rand_instr k=%0d n=%0d got=%h exp=%h", k, n, ri[k], ins_m[k]); end
          if (rp[k] !== opc_m[k]) begin n_errors++; $display("FAIL rand_pc k=%0d n=%0d got=%h exp=%h", k, n, rp[k], opc_m[k]); end
        end
      end
      next_cycle();
    end
    rst = 1'b0;
    quiet();
    repeat (4) next_cycle();
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_stream();
    test_stall();
    test_flush();
    test_rbw();
    test_reset_mid();
    test_alias();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder serving the fetch stage's PC requests over a valid/ready handshake.
- Models a word-addressed 16-bit instruction store with configurable wait states.
- Returns the instruction tagged with its PC, holding it stable while decode stalls.
- Supports redirect flush (jump/branch, halt) and a side-band load port used to preload the program.

Parameters:
- ADDR_W, 8, word-address bits actually decoded; DEPTH = 2^ADDR_W words.
- LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  fetch presents a PC
- req_addr  in  16  requested PC, word address
- req_ready  out  1  responder accepts request this cycle
- resp_valid  out  1  resp_instr/resp_pc valid
- resp_ready  in  1  decode consumes response (low = stall)
- resp_instr  out  16  fetched instruction
- resp_pc  out  16  full 16-bit PC of resp_instr
- flush  in  1  redirect: cancel in-flight or held response
- load_en  in  1  preload write strobe
- load_addr  in  16  preload word address
- load_data  in  16  preload data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE, counter=0.
  - resp_valid=0, resp_instr=16'h0000, resp_pc=16'h0000.
  - req_ready=0 while rst is high.
  - Memory contents are not cleared by rst.
- States:
  - IDLE: no request outstanding.
  - WAIT: counting wait states.
  - RESP: response presented.
- req_ready = !rst && (state==IDLE || (state==RESP && resp_ready)). It is combinational.
- Accept = req_valid && req_ready.
  - On accept: latch req_addr into pc_q.
  - If LATENCY==1: read the array and go to RESP next cycle.
  - Otherwise: counter=LATENCY-2 and go to WAIT.
- WAIT:
  - If counter==0: read the array at pc_q[ADDR_W-1:0] into resp_instr, set resp_pc=pc_q, go to RESP.
  - Otherwise decrement counter.
- RESP:
  - resp_valid=1.
  - resp_instr and resp_pc are held unchanged while resp_ready=0.
  - If resp_ready=1 and no accept: go to IDLE, resp_valid=0 next cycle.
  - If resp_ready=1 and accept: back-to-back transfer. The next request starts, as in IDLE.
  - With LATENCY=1 this gives one instruction per cycle.
- Latency: a request accepted at cycle t gives resp_valid at cycle t+LATENCY.
- Addressing: upper req_addr bits above ADDR_W are ignored for the array index (modulo DEPTH). resp_pc still returns all 16 bits.
- Flush has priority over everything except rst.
  - flush=1 in WAIT or RESP: discard the transaction, resp_valid=0 next cycle, go to IDLE.
  - The response at a flush edge does not count as consumed, even if resp_ready=1.
  - req_ready is forced to 1 during flush (unless rst), so a redirected PC presented in the same cycle as flush is accepted. Its response appears LATENCY cycles later.
  - Flush in IDLE with no request has no effect.
- Load port:
  - Synchronous write when load_en=1, independent of FSM state.
  - The array read happens at the WAIT→RESP (or accept→RESP) edge.
  - A load to the same address on that same edge: the response returns the OLD data (read-before-write).
  - Loads after capture do not alter a held response.
- Reset mid-transaction: any WAIT or RESP is abandoned. Outputs return to their reset values the next cycle.
- Counter width is 4 bits. LATENCY outside 1..15 is a compile-time error.

Decomposition:
- Shared package (fetch_pkg) holds:
  - the state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - WORD_W=16;
  - the NOP encoding used by decode for bubbles.
- One sub-module, imem_array:
  - DEPTH×16 storage;
  - synchronous write port (load);
  - combinational read;
  - no reset.
- imem_responder owns the FSM, wait counter, and response registers.

Test Plan:
- Preload addr 0x10=0xA5A5. With LATENCY=2, req at 0x0010 in cycle t → resp_valid=1 at t+2, resp_instr=0xA5A5, resp_pc=0x0010.
- With LATENCY=1, resp_ready=1, requests 0x0..0x3 streamed back-to-back → four responses on consecutive cycles with matching PCs, req_ready never low.
- Hold resp_ready=0 for 5 cycles while resp_valid → resp_instr and resp_pc stable, req_ready=0. Then raise resp_ready → one handshake, then IDLE.
- LATENCY=3: req 0x20, flush at cycle t+1 together with req 0x40 → no response for 0x20; response for 0x40 at t+4.
- Loads:
  - load_en writes 0x1234 to 0x30 on the same edge a read of 0x30 captures → response returns the prior value.
  - A later request to 0x30 returns 0x1234.
- Alias and reset:
  - req 0x0110 with ADDR_W=8 → resp_instr equals mem[0x10], resp_pc=0x0110.
  - Assert rst during WAIT → resp_valid=0 and IDLE next cycle; memory preserved.
